mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
- Iterative radix-2 shift-add multiplier controller for the RV32M multiply ops: MUL, MULH, MULHSU and MULHU.
- Sits in EX beside the ALU. When the decoded ALU op is a multiply, the pipeline raises start_i and holds the instruction in EX while stall_o is high.
- The block sequences operand sign handling, 32 add/shift iterations and the final negate. It returns a single 32-bit result with a one-cycle done_o pulse.

Parameters:
- XLEN, 32, operand/result width. Counter width is clog2(XLEN)+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  multiply request. Held high by the pipeline while stall_o is high.
- op_i  in  2  funct3[1:0]: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU. Sampled only on accept.
- rs1_i  in  XLEN  multiplicand. Sampled only on accept.
- rs2_i  in  XLEN  multiplier. Sampled only on accept.
- flush_i  in  1  abort the in-flight op (branch/jump redirect)
- stall_o  out  1  freeze IF/ID/EX
- done_o  out  1  one-cycle pulse: result_o valid
- result_o  out  XLEN  multiply result. Held until the next done_o.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, counter=0, accumulator=0, done_o=0, result_o=0. stall_o=0 while start_i=0.
- States: IDLE, CALC, FIXUP, DONE.

State transitions:
- IDLE, start_i=1 and flush_i=0: accept. Latch op, operands and sign flags.
  - If either operand is 0, go to DONE with result 0.
  - Otherwise go to CALC with counter=XLEN.
- CALC: each cycle, if multiplier bit0=1, add the multiplicand magnitude into acc[2*XLEN-1:XLEN] with carry. Shift the {acc, multiplier} pair right by 1 and decrement the counter. When the counter reaches 1, go to FIXUP.
- FIXUP: if neg flag is set, two's-complement the 2*XLEN product. Go to DONE.
- DONE: drive done_o=1 and result_o. Return to IDLE. start_i is ignored in this cycle, since it is the same held instruction.

Sign rules:
- MUL: both operands unsigned; take the low word.
- MULH: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU: both operands unsigned.
- Signed operands are converted to magnitudes; neg = sign1 XOR sign2, counting only the signed operands.
- Result: MUL takes product[XLEN-1:0]; all other ops take product[2*XLEN-1:XLEN].

Latency:
- Nonzero operands: accept in cycle 0, CALC cycles 1..32, FIXUP cycle 33, done_o in cycle 34.
- Zero-operand shortcut: done_o in cycle 1.
- -2^31 magnitude is 0x80000000 unsigned; no overflow.

stall_o:
- stall_o = (IDLE and start_i and not flush_i) or CALC or FIXUP. It is combinational from start_i in IDLE, so the requesting instruction stalls in its first cycle.
- stall_o=0 in DONE, so the pipeline advances exactly once with result_o.

Flush and reset:
- flush_i in CALC or FIXUP: next state IDLE, no done_o, stall_o drops the same cycle.
- flush_i in DONE: done_o still pulses; the pipeline discards the result.
- rst_i overrides everything, including mid-CALC. The next cycle is IDLE with all outputs at their reset values.

Back-to-back:
- A new start_i in the cycle after DONE is accepted normally.
- Two consecutive multiplies give a 35-cycle period.

Test Plan:
- Basic MUL: MUL rs1=7, rs2=6. Expect stall_o high for cycles 0..33, done_o in cycle 34, result_o=0x0000002A.
- MULH signed: MULH 0x80000000 x 0x80000000 gives result 0x40000000. MULH 0xFFFFFFFF x 0xFFFFFFFF gives result 0x00000000.
- Mixed and unsigned high word: MULHSU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE.
- Zero shortcut and back-to-back:
  - MUL rs1=0, rs2=0x1234: done_o in cycle 1, result 0, stall_o high for cycle 0 only.
  - Then immediately MUL 3x5: result 0x0F, 34 cycles later.
- Flush: assert flush_i at CALC cycle 10. Expect stall_o=0 that cycle, no done_o, IDLE next. A following MUL 2x2 returns 4 with normal latency.
- Reset: pulse rst_i at CALC cycle 20. Next cycle expect IDLE with done_o=0, result_o=0, stall_o=0. Random regression of 10k ops across all op_i values must match a reference model.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative radix-2 shift-add multiplier sequencer for RV32M MUL/MULH/MULHSU/MULHU
module mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo, r_mcand, r_result;
    logic              r_neg, r_low;
    logic              w_accept, w_zero, w_s1, w_s2;
    logic [XLEN-1:0]   w_mag1, w_mag2, w_add;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod;

    assign w_accept = r_state == IDLE && start_i && !flush_i;
    assign w_s1     = (op_i == 2'd1 || op_i == 2'd2) && rs1_i[XLEN-1];
    assign w_s2     = op_i == 2'd1 && rs2_i[XLEN-1];
    assign w_mag1   = w_s1 ? -rs1_i : rs1_i;
    assign w_mag2   = w_s2 ? -rs2_i : rs2_i;
    assign w_zero   = rs1_i == '0 || rs2_i == '0;
    assign w_add    = r_lo[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_add};
    assign w_prod   = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign result_o = r_result;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state, pipeline stall and done pulse; a flush drops stall in the same cycle
    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            IDLE: begin
                stall_o = start_i && !flush_i;
                w_next  = w_accept ? (w_zero ? DONE : CALC) : IDLE;
            end
            CALC: begin
                stall_o = !flush_i;
                w_next  = flush_i ? IDLE : (r_cnt == CW'(1) ? FIXUP : CALC);
            end
            FIXUP: begin
                stall_o = !flush_i;
                w_next  = flush_i ? IDLE : DONE;
            end
            default: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    // datapath: latch magnitudes on accept, one add/shift per CALC cycle, signed fixup into result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_low    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= CW'(XLEN);
            r_hi    <= '0;
            r_lo    <= w_mag2;
            r_mcand <= w_mag1;
            r_neg   <= w_s1 ^ w_s2;
            r_low   <= op_i == 2'd0;
            if (w_zero) r_result <= '0;
        end else if (r_state == CALC && !flush_i) begin
            r_cnt <= r_cnt - 1'b1;
            r_hi  <= w_sum[XLEN:1];
            r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
        end else if (r_state == FIXUP && !flush_i) begin
            r_result <= r_low ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end
endmodule
